uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single UART transmitter.
// Latches the winning frame, launches it, then tracks tx_busy to completion or timeout.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [3:0]              req_valid,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  input  logic [3:0]              req_par_en,
  output logic [3:0]              req_ready,
  input  logic                    tx_busy,
  output logic                    tx_data_valid,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_par_en,
  output logic [1:0]              grant_id,
  output logic                    frame_done,
  output logic                    timeout_err
);

  localparam int             CW        = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(BUSY_TIMEOUT);

  // Three-bit encoding leaves spare codes that the default branch recovers from.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;

  logic [2:0]    state_r;
  logic [2:0]    state_nx_s;
  logic [1:0]    last_grant_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic [2:0]    pick_s;
  logic          hs_s;
  logic          timeout_s;
  logic          done_s;

  // Round-robin pick: {found, index}; rotates the request vector so the slot
  // after last_grant sits at bit 0, then priority-encodes upward.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] base;
    base = last + 2'd1;
    dbl  = {v, v} >> base;
    rot  = dbl[3:0];
    if (rot[0])      rr_pick = {1'b1, base};
    else if (rot[1]) rr_pick = {1'b1, base + 2'd1};
    else if (rot[2]) rr_pick = {1'b1, base + 2'd2};
    else if (rot[3]) rr_pick = {1'b1, base + 2'd3};
    else             rr_pick = 3'b000;
  endfunction

  assign pick_s = rr_pick(req_valid, last_grant_r);

  // One-hot accept, only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = 4'b0000;
    if (rstn && (state_r == IDLE) && pick_s[2]) begin
      req_ready = 4'b0001 << pick_s[1:0];
    end else begin
      req_ready = 4'b0000;
    end
  end

  assign hs_s      = |(req_valid & req_ready);
  assign cnt_inc_s = (cnt_r >= CNT_LIMIT) ? CNT_LIMIT : cnt_r + CW'(1);
  assign timeout_s = (state_r == WAIT_BUSY) && !tx_busy && (cnt_inc_s == CNT_LIMIT);
  assign done_s    = (state_r == WAIT_DONE) && !tx_busy;

  // Completion pulses coincide with the last cycle of the frame so IDLE follows them.
  assign frame_done  = done_s;
  assign timeout_err = timeout_s;

  // Next-state decode.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE: begin
        if (hs_s) state_nx_s = LOAD;
        else      state_nx_s = IDLE;
      end
      LOAD: begin
        state_nx_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)        state_nx_s = WAIT_DONE;
        else if (timeout_s) state_nx_s = IDLE;
        else                state_nx_s = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx_s = IDLE;
        else          state_nx_s = WAIT_DONE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Busy-wait counter: cleared during LOAD, saturating count of idle WAIT_BUSY cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (state_r == LOAD) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT_BUSY) && !tx_busy) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Fairness pointer advances only when a frame finishes or times out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_r <= 2'd3;
    end else if (done_s || timeout_s) begin
      last_grant_r <= grant_id;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Frame capture at the handshake; held until the next handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_p_data <= '0;
      tx_par_en <= 1'b0;
      grant_id  <= 2'd0;
    end else if (hs_s) begin
      tx_p_data <= req_data[pick_s[1:0]*DATA_WIDTH +: DATA_WIDTH];
      tx_par_en <= req_par_en[pick_s[1:0]];
      grant_id  <= pick_s[1:0];
    end else begin
      tx_p_data <= tx_p_data;
      tx_par_en <= tx_par_en;
      grant_id  <= grant_id;
    end
  end

  // Launch strobe is high exactly during LOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_data_valid <= 1'b0;
    else       tx_data_valid <= hs_s;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter with a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk;
  logic          rstn;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_par_en;
  logic [3:0]    req_ready;
  logic          tx_busy;
  logic          tx_data_valid;
  logic [DW-1:0] tx_p_data;
  logic          tx_par_en;
  logic [1:0]    grant_id;
  logic          frame_done;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int m_last = 3;

  // Observations from the most recent frame
  bit          o_hs_ok;
  logic [3:0]  o_ready;
  logic        o_dv;
  logic [DW-1:0] o_data;
  logic        o_par;
  logic [1:0]  o_gid;
  int          o_done_c;
  int          o_to_c;
  logic [DW-1:0] o_data_end;
  logic        o_par_end;
  logic [1:0]  o_gid_end;
  bit          o_leak;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_ready(req_ready), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data), .tx_par_en(tx_par_en),
    .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: first requesting index strictly after the previous owner, wrapping mod 4
  function automatic int model_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] slice(input logic [4*DW-1:0] d, input int i);
    return d[i*DW +: DW];
  endfunction

  // Runs one frame; busy_len = 0 means tx_busy never rises (timeout path)
  task automatic do_frame(input logic [3:0] v, input logic [4*DW-1:0] d, input logic [3:0] p,
                          input int busy_len, input bit busy_in_load, input bit hold,
                          input bit scramble);
    int k;
    req_valid = v; req_data = d; req_par_en = p; tx_busy = 1'b0;
    o_hs_ok = 0; o_ready = 4'b0; o_dv = 1'b0; o_data = '0; o_par = 1'b0; o_gid = 2'd0;
    o_done_c = 0; o_to_c = 0; o_data_end = '0; o_par_end = 1'b0; o_gid_end = 2'd0; o_leak = 0;
    #1;
    k = 0;
    while (((req_ready & req_valid) == 4'b0) && (k < 20)) begin
      tick; #1; k++;
    end
    if ((req_ready & req_valid) == 4'b0) begin
      req_valid = 4'b0;
      return;
    end
    o_hs_ok = 1;
    o_ready = req_ready;
    tick;
    if (!hold) req_valid = 4'b0;
    tx_busy = busy_in_load;
    #1;
    o_dv = tx_data_valid; o_data = tx_p_data; o_par = tx_par_en; o_gid = grant_id;
    if (req_ready != 4'b0) o_leak = 1;
    for (int c = 1; c <= 60; c++) begin
      tick;
      tx_busy = (c <= busy_len);
      if (scramble) begin
        req_data = {$urandom};
        req_par_en = 4'($urandom);
        if (!hold) req_valid = 4'($urandom);
      end
      #1;
      if ((req_ready != 4'b0) || tx_data_valid) o_leak = 1;
      if (frame_done && (o_done_c == 0)) o_done_c = c;
      if (timeout_err && (o_to_c == 0)) o_to_c = c;
      if (frame_done || timeout_err) begin
        o_data_end = tx_p_data; o_par_end = tx_par_en; o_gid_end = grant_id;
        break;
      end
    end
    tick;
    tx_busy = 1'b0;
    req_valid = 4'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req_valid = 4'b1111; req_data = 32'h11223344; req_par_en = 4'b1111; tx_busy = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    n_cmp++; if ({tx_data_valid, tx_p_data, tx_par_en, grant_id, frame_done, timeout_err} !== 14'b0) begin
      n_bad++; $display("FAIL reset_outputs dv=%b data=%h par=%b gid=%0d done=%b to=%b",
                        tx_data_valid, tx_p_data, tx_par_en, grant_id, frame_done, timeout_err); end
    tick; tick;
    rstn = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
    req_valid = 4'b0;
    m_last = 3;
    tick;
  endtask

  task automatic test_single;
    do_frame(4'b0001, 32'h000000A5, 4'b0001, 11, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b want=0001", o_ready); end
    n_cmp++; if (o_dv !== 1'b1 || o_data !== 8'hA5 || o_par !== 1'b1) begin
      n_bad++; $display("FAIL single_load dv=%b data=%h par=%b want 1 a5 1", o_dv, o_data, o_par); end
    n_cmp++; if (o_done_c !== 12 || o_to_c !== 0) begin
      n_bad++; $display("FAIL single_done done_cycle=%0d to_cycle=%0d want 12 0", o_done_c, o_to_c); end
    n_cmp++; if (o_gid_end !== 2'd0 || o_leak) begin
      n_bad++; $display("FAIL single_gid gid=%0d leak=%0d want 0 0", o_gid_end, o_leak); end
    m_last = 0;
  endtask

  task automatic test_round_robin;
    int exp_order[5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      do_frame(4'b1111, {$urandom}, 4'($urandom), 2 + i, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (!o_hs_ok || o_gid !== 2'(exp_order[i]) || o_done_c !== 3 + i) begin
        n_bad++; $display("FAIL rr_grant[%0d] hs=%0d gid=%0d done_c=%0d want gid=%0d done_c=%0d",
                          i, o_hs_ok, o_gid, o_done_c, exp_order[i], 3 + i); end
      m_last = exp_order[i];
    end
  endtask

  task automatic test_skip_idle;
    do_frame(4'b0010, 32'h0000_5500, 4'b0000, 1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_gid !== 2'd1) begin n_bad++; $display("FAIL skip_setup gid=%0d want 1", o_gid); end
    do_frame(4'b1001, 32'h7700_0066, 4'b1000, 3, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (o_gid !== 2'd3 || o_data !== 8'h77 || o_par !== 1'b1) begin
      n_bad++; $display("FAIL skip_to_3 gid=%0d data=%h par=%b want 3 77 1", o_gid, o_data, o_par); end
    do_frame(4'b1001, 32'h7700_0066, 4'b1000, 3, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (o_gid !== 2'd0 || o_data !== 8'h66 || o_par !== 1'b0) begin
      n_bad++; $display("FAIL skip_to_0 gid=%0d data=%h par=%b want 0 66 0", o_gid, o_data, o_par); end
    m_last = 0;
  endtask

  task automatic test_timeout;
    do_frame(4'b0100, 32'h0042_0000, 4'b0100, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_to_c !== TO || o_done_c !== 0) begin
      n_bad++; $display("FAIL timeout_pulse to_cycle=%0d done_cycle=%0d want %0d 0", o_to_c, o_done_c, TO); end
    n_cmp++; if (o_gid !== 2'd2 || o_leak) begin
      n_bad++; $display("FAIL timeout_gid gid=%0d leak=%0d want 2 0", o_gid, o_leak); end
    m_last = 2;
    do_frame(4'b0101, 32'h0011_0022, 4'b0000, 2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (!o_hs_ok || o_gid !== 2'd0 || o_done_c !== 3) begin
      n_bad++; $display("FAIL timeout_next hs=%0d gid=%0d done_c=%0d want 1 0 3", o_hs_ok, o_gid, o_done_c); end
    m_last = 0;
  endtask

  task automatic test_data_stability;
    do_frame(4'b0001, 32'h0000_003C, 4'b0000, 6, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (o_data !== 8'h3C || o_data_end !== 8'h3C || o_gid_end !== 2'd0) begin
      n_bad++; $display("FAIL stability data_load=%h data_end=%h gid_end=%0d want 3c 3c 0",
                        o_data, o_data_end, o_gid_end); end
    #1;
    n_cmp++; if (tx_p_data !== 8'h3C) begin n_bad++; $display("FAIL stability_idle data=%h want 3c", tx_p_data); end
    m_last = 0;
  endtask

  task automatic test_reset_mid_frame;
    req_valid = 4'b0001; req_data = 32'h0000_00C3; req_par_en = 4'b0001; tx_busy = 1'b0;
    tick;
    req_valid = 4'b0000;
    tick;
    tx_busy = 1'b1;
    tick; tick;
    req_valid = 4'b0110;
    rstn = 1'b0;
    #1;
    n_cmp++; if ({req_ready, tx_data_valid, tx_p_data, tx_par_en, grant_id, frame_done, timeout_err} !== 18'b0) begin
      n_bad++; $display("FAIL rst_mid_outputs ready=%b dv=%b data=%h par=%b gid=%0d done=%b to=%b",
                        req_ready, tx_data_valid, tx_p_data, tx_par_en, grant_id, frame_done, timeout_err); end
    tick;
    tx_busy = 1'b0;
    rstn = 1'b1;
    m_last = 3;
    do_frame(4'b0110, 32'h0000_9900, 4'b0010, 2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_ready !== 4'b0010 || o_gid !== 2'd1 || o_data !== 8'h99) begin
      n_bad++; $display("FAIL rst_mid_regrant ready=%b gid=%0d data=%h want 0010 1 99", o_ready, o_gid, o_data); end
    m_last = 1;
  endtask

  task automatic test_random;
    logic [3:0]    v;
    logic [4*DW-1:0] d;
    logic [3:0]    p;
    int            bl;
    int            eg;
    for (int i = 0; i < 30; i++) begin
      v = 4'($urandom_range(1, 15));
      d = {$urandom};
      p = 4'($urandom);
      bl = $urandom_range(0, 6);
      eg = model_pick(v, m_last);
      do_frame(v, d, p, bl, 1'($urandom), 1'($urandom), 1'b1);
      n_cmp++; if (!o_hs_ok || o_ready !== (4'b0001 << eg) || o_gid !== 2'(eg)) begin
        n_bad++; $display("FAIL rand_grant[%0d] v=%b hs=%0d ready=%b gid=%0d want gid=%0d",
                          i, v, o_hs_ok, o_ready, o_gid, eg); end
      n_cmp++; if (o_dv !== 1'b1 || o_data !== slice(d, eg) || o_par !== p[eg]) begin
        n_bad++; $display("FAIL rand_load[%0d] dv=%b data=%h par=%b want 1 %h %b",
                          i, o_dv, o_data, o_par, slice(d, eg), p[eg]); end
      n_cmp++; if (o_done_c !== ((bl == 0) ? 0 : bl + 1) || o_to_c !== ((bl == 0) ? TO : 0)) begin
        n_bad++; $display("FAIL rand_end[%0d] busy_len=%0d done_c=%0d to_c=%0d", i, bl, o_done_c, o_to_c); end
      n_cmp++; if (o_leak || o_data_end !== slice(d, eg) || o_gid_end !== 2'(eg)) begin
        n_bad++; $display("FAIL rand_hold[%0d] leak=%0d data_end=%h gid_end=%0d want 0 %h %0d",
                          i, o_leak, o_data_end, o_gid_end, slice(d, eg), eg); end
      m_last = eg;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_skip_idle;
    test_timeout;
    test_data_stability;
    test_reset_mid_frame;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
